// File: rtl/pixbuf_pkg.sv
// Shared constants, FSM state type and idle pin values for the pixel buffer arbiter.
package pixbuf_pkg;

  localparam int PB_ADDR_W       = 19;
  localparam int PB_DATA_W       = 32;
  localparam int PB_RD_LAT       = 2;
  localparam int PB_MAX_RD_BURST = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    TURN = 2'd2,
    WR   = 2'd3
  } pixbuf_state_e;

  localparam logic IDLE_ADSC_N = 1'b1;
  localparam logic IDLE_CE_N   = 1'b1;
  localparam logic IDLE_WE_N   = 1'b1;
  localparam logic IDLE_DQ_OE  = 1'b0;

endpackage

// File: rtl/pixbuf_rd_pipe.sv
// Tracks in-flight SSRAM reads and registers the returned word out one cycle
// after DQ is sampled.
module pixbuf_rd_pipe #(
  parameter int DATA_W = pixbuf_pkg::PB_DATA_W,
  parameter int RD_LAT = pixbuf_pkg::PB_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [DATA_W-1:0] dq_in,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // Bit k set means a read was on the pins k cycles ago; bit RD_LAT is the sample cycle.
  logic [RD_LAT:0]   vld_q, vld_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    vld_d    = {vld_q[RD_LAT-1:0], issue};
    rvalid_d = vld_q[RD_LAT];
    rdata_d  = vld_q[RD_LAT] ? dq_in : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy   = |vld_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/pixel_buffer_arbiter.sv
// Arbitrates the single-port pipelined SSRAM between scanout reads and PPU writes.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module pixel_buffer_arbiter
  import pixbuf_pkg::*;
#(
  parameter int ADDR_W       = PB_ADDR_W,
  parameter int DATA_W       = PB_DATA_W,
  parameter int RD_LAT       = PB_RD_LAT,
  parameter int MAX_RD_BURST = PB_MAX_RD_BURST
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset_n,
  input  logic                                  rd_valid,
  input  logic [ADDR_W-1:0]                     rd_addr,
  output logic                                  rd_ready,
  output logic                                  rd_rvalid,
  output logic [DATA_W-1:0]                     rd_rdata,
  input  logic                                  wr_valid,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic [DATA_W/8-1:0]                   wr_be,
  output logic                                  wr_ready,
  output logic [ADDR_W-1:0]                     sram_addr,
  output logic                                  sram_adsc_n,
  output logic                                  sram_ce_n,
  output logic                                  sram_we_n,
  output logic                                  sram_oe_n,
  output logic [DATA_W/8-1:0]                   sram_be_n,
  output logic [DATA_W-1:0]                     sram_dq_out,
  output logic                                  sram_dq_oe,
  input  logic [DATA_W-1:0]                     sram_dq_in,
  output logic [1:0]                            dbg_state,
  output logic [$clog2(MAX_RD_BURST+1)-1:0]     dbg_rd_streak,
  output logic [$clog2(RD_LAT+1)-1:0]           dbg_drain
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_RD_BURST + 1);
  localparam int DRAIN_W  = $clog2(RD_LAT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_BURST);
  localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(RD_LAT);

  pixbuf_state_e       state_q, state_d;
  logic [STREAK_W-1:0] rd_streak_q, rd_streak_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                adsc_n_q, adsc_n_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                force_wr, rd_grant, wr_grant, rd_busy;

  // A starved write keeps rd_ready low through the read-to-write turnaround.
  always_comb begin
    force_wr = wr_valid && (rd_streak_q >= STREAK_MAX);
    wr_ready = wr_valid && (drain_q == '0) && (!rd_valid || force_wr);
    rd_ready = !force_wr && !wr_ready;
    rd_grant = rd_valid && rd_ready;
    wr_grant = wr_valid && wr_ready;
  end

  always_comb begin
    state_d     = state_q;
    rd_streak_d = '0;
    drain_d     = (drain_q != '0) ? drain_q - DRAIN_W'(1) : '0;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    adsc_n_d    = IDLE_ADSC_N;
    ce_n_d      = IDLE_CE_N;
    we_n_d      = IDLE_WE_N;
    be_n_d      = '1;
    dq_oe_d     = IDLE_DQ_OE;

    if (wr_grant) begin
      rd_streak_d = '0;
    end else if (rd_grant) begin
      rd_streak_d = (rd_streak_q < STREAK_MAX) ? rd_streak_q + STREAK_W'(1) : rd_streak_q;
    end else if (force_wr) begin
      rd_streak_d = rd_streak_q;
    end

    if (rd_grant) begin
      drain_d  = DRAIN_LOAD;
      addr_d   = rd_addr;
      adsc_n_d = 1'b0;
      ce_n_d   = 1'b0;
      be_n_d   = '0;
    end else if (wr_grant) begin
      addr_d   = wr_addr;
      dq_out_d = wr_data;
      adsc_n_d = 1'b0;
      ce_n_d   = 1'b0;
      we_n_d   = 1'b0;
      be_n_d   = ~wr_be;
      dq_oe_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rd_grant)      state_d = RD;
        else if (wr_grant) state_d = WR;
        else               state_d = IDLE;
      end
      RD, TURN: begin
        if (rd_grant)                           state_d = RD;
        else if (wr_grant)                      state_d = WR;
        else if (wr_valid && (drain_q != '0))   state_d = TURN;
        else                                    state_d = IDLE;
      end
      WR: begin
        if (rd_grant)      state_d = RD;
        else if (wr_grant) state_d = WR;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_streak_q <= '0;
      drain_q     <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      adsc_n_q    <= 1'b1;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_streak_q <= rd_streak_d;
      drain_q     <= drain_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      adsc_n_q    <= adsc_n_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  pixbuf_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .issue  (rd_grant),
    .dq_in  (sram_dq_in),
    .busy   (rd_busy),
    .rvalid (rd_rvalid),
    .rdata  (rd_rdata)
  );

  // Output enable spans command through sample cycle of the newest read.
  assign sram_oe_n     = !rd_busy || dq_oe_q;
  assign sram_addr     = addr_q;
  assign sram_adsc_n   = adsc_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_be_n     = be_n_q;
  assign sram_dq_out   = dq_out_q;
  assign sram_dq_oe    = dq_oe_q;
  assign dbg_state     = state_q;
  assign dbg_rd_streak = rd_streak_q;
  assign dbg_drain     = drain_q;

endmodule
